// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between NREQ byte producers: arbitration, free-running baud tick, frame strobes.
// Define RR_ARB_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module uart_tx_sched #(
    parameter int NREQ       = 2,
    parameter int CLK_DIV    = 16,
    parameter int FRAME_BITS = 10
) (
    input  logic                    clk_sis,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    baud_tick,
    output logic                    start_bit,
    output logic [7:0]              uart_data,
    output logic                    stop_bit,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_PRE = CW'(CLK_DIV - 2);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_SEND = 2'd2} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            tick_q;
    logic [BW-1:0]   bit_q;
    logic            busy_q;
    logic            start_q;
    logic            stop_q;
    logic [7:0]      data_q;
    logic [IW-1:0]   grant_q;

    logic [IW-1:0]   ptr_s;
    logic [IW-1:0]   win_s;
    logic            found_s;
    int              idx_s;
    logic            accept_s;
    logic            tick_pre_s;

`ifdef RR_ARB_EN
    logic [IW-1:0] ptr_q;

    // Round-robin pointer moves past the granted requester on every accept
    always_ff @(posedge clk_sis or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if (accept_s) begin
            ptr_q <= (win_s == IW'(NREQ - 1)) ? '0 : win_s + 1'b1;
        end
    end
    assign ptr_s = ptr_q;
`else
    assign ptr_s = '0;
`endif

    // Winner = first valid requester searching upward from the pointer, wrapping
    always_comb begin
        win_s   = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (int'(ptr_s) + k >= NREQ) begin
                idx_s = int'(ptr_s) + k - NREQ;
            end else begin
                idx_s = int'(ptr_s) + k;
            end
            if (!found_s && req_valid[IW'(idx_s)]) begin
                found_s = 1'b1;
                win_s   = IW'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Gating with rst keeps req_ready low while reset is asserted
    assign accept_s   = rst && (state_q == S_IDLE) && found_s;
    assign req_ready  = accept_s ? ({{(NREQ-1){1'b0}}, 1'b1} << win_s) : '0;
    assign tick_pre_s = (cnt_q == CNT_PRE);

    // Free-running baud divider; tick is registered one cycle ahead of the count wrap
    always_ff @(posedge clk_sis or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
            tick_q <= tick_pre_s;
        end
    end

    // Frame sequencer; strobes use the lookahead so they line up with baud_tick
    always_ff @(posedge clk_sis or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            data_q  <= 8'h00;
            grant_q <= '0;
        end else begin
            start_q <= tick_pre_s && (accept_s || (state_q == S_WAIT));
            stop_q  <= tick_pre_s && (state_q == S_SEND) && (bit_q == BW'(1));
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        data_q  <= req_data[{win_s, 3'b000} +: 8];
                        grant_q <= win_s;
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tick_q) begin
                        bit_q   <= BW'(FRAME_BITS - 1);
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tick_q) begin
                        bit_q <= bit_q - 1'b1;
                        if (bit_q == BW'(1)) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign baud_tick = tick_q;
    assign start_bit = start_q;
    assign stop_bit  = stop_q;
    assign busy      = busy_q;
    assign uart_data = data_q;
    assign grant_id  = grant_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched (NREQ=2, CLK_DIV=4, FRAME_BITS=10) with a timestamp-based frame model.
module tb_uart_tx_sched;
    localparam int DIV = 4;
    localparam int FB  = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] valid;
    logic [7:0] d0, d1;
    logic [1:0] rdy;
    logic       tick, start, stop, busy;
    logic [7:0] data;
    logic [0:0] gid;

    uart_tx_sched #(.NREQ(2), .CLK_DIV(DIV), .FRAME_BITS(FB)) dut (
        .clk_sis(clk), .rst(rst), .req_valid(valid), .req_data({d1, d0}),
        .req_ready(rdy), .baud_tick(tick), .start_bit(start), .uart_data(data),
        .stop_bit(stop), .busy(busy), .grant_id(gid)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int cyc = 0, last_tick = -1;
    // frame model: timestamps of accept, start strobe and stop strobe of the latest frame
    bit   m_have = 0;
    int   m_acc, m_start, m_stop, m_ptr = 0;
    logic [7:0] m_data = 8'h00;
    logic [0:0] m_gid = 1'b0;
    logic obs_start, obs_stop, obs_tick;
    logic [1:0] obs_rdy;
    logic [7:0] obs_data;
    logic [0:0] obs_gid;

    typedef struct {
        logic [1:0] valid;
        logic [7:0] d0, d1;
        logic [0:0] exp_gid;
        logic [7:0] exp_data;
    } vec_t;
    vec_t vt[6];

    task automatic model_reset();
        m_have = 0; m_ptr = 0; m_data = 8'h00; m_gid = 1'b0;
        last_tick = -1;
    endtask

    task automatic check_zero(input string name);
        logic [14:0] act;
        act = {rdy, tick, start, data, stop, busy, gid};
        n_vec++;
        if (act !== 15'd0) begin
            n_err++;
            $display("FAIL %s outputs act=%h exp=0000", name, act);
        end
    endtask

    task automatic cycle();
        logic [1:0]  e_rdy;
        logic [14:0] exp, act;
        bit idle;
        int w, t;
        @(negedge clk);
        idle  = !m_have || (cyc > m_stop);
        e_rdy = 2'b00;
        w = -1;
        if (idle) begin
            for (int k = 0; k < 2; k++)
                if (w < 0 && valid[(m_ptr + k) % 2]) w = (m_ptr + k) % 2;
        end
        if (w >= 0) e_rdy[w] = 1'b1;
        exp = {e_rdy, 1'((cyc % DIV) == DIV - 1), 1'(m_have && cyc == m_start), m_data,
               1'(m_have && cyc == m_stop), 1'(m_have && cyc > m_acc && cyc <= m_stop), m_gid};
        act = {rdy, tick, start, data, stop, busy, gid};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL cyc%0d outs {rdy,tick,start,data,stop,busy,gid} act=%h exp=%h", cyc, act, exp);
        end
        obs_start = start; obs_stop = stop; obs_tick = tick;
        obs_rdy = rdy; obs_data = data; obs_gid = gid;
        if (tick) begin
            if (last_tick >= 0) begin
                n_vec++;
                if (cyc - last_tick != DIV) begin
                    n_err++;
                    $display("FAIL tick_gap act=%0d exp=%0d", cyc - last_tick, DIV);
                end
            end
            last_tick = cyc;
        end
        if (w >= 0) begin
            t = cyc + 1;
            while ((t % DIV) != DIV - 1) t++;
            m_have = 1; m_acc = cyc; m_start = t; m_stop = t + (FB - 1) * DIV;
            m_data = (w == 1) ? d1 : d0;
            m_gid = 1'(w);
`ifdef RR_ARB_EN
            m_ptr = (w + 1) % 2;
`endif
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_start(input string name, input logic [0:0] egid, input logic [7:0] edata);
        bit got = 0;
        for (int n = 0; n < 3 * DIV && !got; n++) begin
            cycle();
            got = obs_start;
        end
        n_vec++;
        if (!got || obs_gid !== egid || obs_data !== edata) begin
            n_err++;
            $display("FAIL %s start seen=%0d gid=%0d data=%h exp gid=%0d data=%h",
                     name, got, obs_gid, obs_data, egid, edata);
        end
    endtask

    task automatic wait_stop(input string name);
        bit got = 0;
        for (int n = 0; n < FB * DIV + 8 && !got; n++) begin
            cycle();
            got = obs_stop;
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL %s stop_bit not seen act=0 exp=1", name);
        end
    endtask

    initial begin
        int ticks, stops;
        vt[0] = '{2'b01, 8'hA5, 8'h00, 1'b0, 8'hA5};
`ifdef RR_ARB_EN
        vt[1] = '{2'b11, 8'h11, 8'h22, 1'b1, 8'h22};
        vt[2] = '{2'b11, 8'h11, 8'h22, 1'b0, 8'h11};
        vt[3] = '{2'b11, 8'h11, 8'h22, 1'b1, 8'h22};
        vt[4] = '{2'b11, 8'h11, 8'h22, 1'b0, 8'h11};
`else
        vt[1] = '{2'b11, 8'h11, 8'h22, 1'b0, 8'h11};
        vt[2] = '{2'b11, 8'h11, 8'h22, 1'b0, 8'h11};
        vt[3] = '{2'b11, 8'h11, 8'h22, 1'b0, 8'h11};
        vt[4] = '{2'b11, 8'h11, 8'h22, 1'b0, 8'h11};
`endif
        vt[5] = '{2'b10, 8'h00, 8'h3C, 1'b1, 8'h3C};

        rst = 1'b0; valid = 2'b11; d0 = 8'h5E; d1 = 8'hE5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_zero("reset_hold");
        end
        @(posedge clk); #1;
        valid = 2'b00;
        rst = 1'b1; cyc = 0; model_reset();
        repeat (9) cycle();

        for (int r = 0; r < 6; r++) begin
            valid = vt[r].valid; d0 = vt[r].d0; d1 = vt[r].d1;
            wait_start($sformatf("row%0d", r), vt[r].exp_gid, vt[r].exp_data);
            wait_stop($sformatf("row%0d", r));
        end
        valid = 2'b00;
        repeat (3) cycle();

        // request raised mid-frame must wait for IDLE
        valid = 2'b01; d0 = 8'h5A;
        wait_start("mid_a", 1'b0, 8'h5A);
        repeat (10) cycle();
        valid = 2'b10; d1 = 8'hC3;
        wait_stop("mid_a");
        wait_start("mid_b", 1'b1, 8'hC3);
        valid = 2'b00;
        wait_stop("mid_b");

        // reset on the 5th baud tick of a frame aborts it
        valid = 2'b01; d0 = 8'h77;
        wait_start("abort", 1'b0, 8'h77);
        ticks = 1;
        for (int n = 0; n < 40 && ticks < 4; n++) begin
            cycle();
            if (obs_tick) ticks++;
        end
        repeat (DIV - 1) cycle();
        valid = 2'b11; d0 = 8'h12; d1 = 8'h34;
        rst = 1'b0;
        #1;
        check_zero("abort_now");
        model_reset();
        @(negedge clk); check_zero("abort_hold1");
        @(posedge clk);
        @(negedge clk); check_zero("abort_hold2");
        @(posedge clk); #1;
        rst = 1'b1; cyc = 0;

        // three back-to-back frames; tick spacing checked inside cycle()
        wait_start("after_rst", 1'b0, 8'h12);
        stops = 0;
        for (int n = 0; n < 200 && stops < 3; n++) begin
            cycle();
            if (obs_stop) stops++;
        end
        n_vec++;
        if (stops != 3) begin
            n_err++;
            $display("FAIL b2b_frames stops act=%0d exp=3", stops);
        end

        // randomized traffic against the frame model
        valid = 2'b00;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!valid[i]) begin
                    if ($urandom_range(3) == 0) begin
                        valid[i] = 1'b1;
                        if (i == 0) d0 = 8'($urandom); else d1 = 8'($urandom);
                    end
                end else if (obs_rdy[i] || $urandom_range(15) == 0) begin
                    valid[i] = 1'b0;
                end
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
